// File: rtl/a2_2_pkg.sv
// rtl/a2_2_pkg.sv - shared widths and defaults for the 16-bit priority encoder
package a2_2_pkg;

    localparam int IN_W  = 16;
    localparam int IDX_W = 4;

    localparam logic [IDX_W-1:0] IDX_ZERO = '0;

endpackage

// File: rtl/a2_2_pe4.sv
// rtl/a2_2_pe4.sv - 4-bit highest-bit-wins encoder with any-set flag
module a2_2_pe4 (
    input  logic [3:0] i_d,
    output logic [1:0] o_idx,
    output logic       o_any
);

    // Highest set bit wins; an empty nibble reports index 0 with o_any low
    always_comb begin
        o_idx = 2'd0;
        o_any = |i_d;
        if (i_d[3])      o_idx = 2'd3;
        else if (i_d[2]) o_idx = 2'd2;
        else if (i_d[1]) o_idx = 2'd1;
        else             o_idx = 2'd0;
    end

endmodule

// File: rtl/a2_2_rtl.sv
// rtl/a2_2_rtl.sv - registered 16-bit priority encoder built from a two-level pe4 tree
module a2_2_rtl
    import a2_2_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic [IN_W-1:0]  d,
    output logic [IDX_W-1:0] y,
    output logic             v
);

    logic [1:0] w_leaf_idx [4];
    logic [3:0] w_leaf_any;
    logic [1:0] w_grp_idx;
    logic       w_grp_any;
    logic [IDX_W-1:0] w_idx;

    logic [IDX_W-1:0] r_y;
    logic             r_v;

    // One leaf encoder per nibble; leaf n covers d[4n+3:4n]
    for (genvar g = 0; g < 4; g++) begin : g_leaf
        a2_2_pe4 u_leaf (
            .i_d   (d[4*g +: 4]),
            .o_idx (w_leaf_idx[g]),
            .o_any (w_leaf_any[g])
        );
    end

    // Group select picks the most significant non-empty nibble
    a2_2_pe4 u_grp (
        .i_d   (w_leaf_any),
        .o_idx (w_grp_idx),
        .o_any (w_grp_any)
    );

    // Upper index bits name the nibble, lower bits come from that nibble's leaf
    always_comb begin
        w_idx = IDX_ZERO;
        if (w_grp_any) begin
            w_idx = {w_grp_idx, w_leaf_idx[w_grp_idx]};
        end
    end

    // Result register: reset beats capture enable, otherwise hold when e is low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= IDX_ZERO;
            r_v <= 1'b0;
        end else if (e) begin
            r_y <= w_idx;
            r_v <= w_grp_any;
        end
    end

    assign y = r_y;
    assign v = r_v;

endmodule

// File: tb/tb_a2_2_rtl.sv
// tb/tb_a2_2_rtl.sv - self-checking bench for a2_2_rtl
module tb_a2_2_rtl;

    logic        clk;
    logic        rst;
    logic        e;
    logic [15:0] d;
    logic [3:0]  y;
    logic        v;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] m_y;
    logic       m_v;
    logic       m_known = 1'b0;

    a2_2_rtl dut (
        .clk (clk),
        .rst (rst),
        .e   (e),
        .d   (d),
        .y   (y),
        .v   (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index of most significant 1, and whether any bit is set
    function automatic logic [3:0] ref_idx(input logic [15:0] x);
        for (int i = 15; i >= 0; i--) begin
            if (x[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Model state advances on every rising edge from the inputs seen there
    always @(posedge clk) begin
        if (rst) begin
            m_y     = 4'd0;
            m_v     = 1'b0;
            m_known = 1'b1;
        end else if (e && m_known) begin
            m_y = ref_idx(d);
            m_v = (d != 16'h0000);
        end
    end

    // Every-cycle comparison against the model once reset has been seen
    always @(negedge clk) begin
        if (m_known) begin
            n_tests++;
            if (y !== m_y || v !== m_v) begin
                n_fail++;
                $display("FAIL model_cmp: got y=%0d v=%0b, want y=%0d v=%0b (d=%h)", y, v, m_y, m_v, d);
            end
        end
    end

    task automatic cyc(input logic r, input logic en, input logic [15:0] dd);
        @(negedge clk);
        rst = r;
        e   = en;
        d   = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] ey, input logic ev);
        n_tests++;
        if (y !== ey || v !== ev) begin
            n_fail++;
            $display("FAIL %s: got y=%0d v=%0b, want y=%0d v=%0b", name, y, v, ey, ev);
        end
    endtask

    initial begin
        rst = 1'b1;
        e   = 1'b1;
        d   = 16'hFFFF;

        cyc(1, 1, 16'hFFFF);
        cyc(1, 1, 16'hFFFF);
        chk("reset", 4'd0, 1'b0);
        cyc(0, 1, 16'hFFFF);
        chk("post_reset_ffff", 4'd15, 1'b1);

        cyc(0, 1, 16'h0000); chk("zero", 4'd0, 1'b0);
        cyc(0, 1, 16'h0001); chk("one", 4'd0, 1'b1);
        cyc(0, 1, 16'h8001); chk("p_8001", 4'd15, 1'b1);
        cyc(0, 1, 16'h0180); chk("p_0180", 4'd8, 1'b1);
        cyc(0, 1, 16'h0010); chk("p_0010", 4'd4, 1'b1);
        cyc(0, 1, 16'h7FFF); chk("p_7fff", 4'd14, 1'b1);
        cyc(0, 1, 16'h0020); chk("p_0020", 4'd5, 1'b1);
        cyc(0, 1, 16'h0C00); chk("p_0c00", 4'd11, 1'b1);

        cyc(0, 1, 16'h0400); chk("hold_cap", 4'd10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 16'h0002);
            chk("hold", 4'd10, 1'b1);
        end

        cyc(1, 0, 16'h8000); chk("rst_over_e0", 4'd0, 1'b0);
        cyc(0, 0, 16'h8000); chk("no_cap_e0", 4'd0, 1'b0);
        cyc(0, 1, 16'h0200); chk("first_cap", 4'd9, 1'b1);
        cyc(1, 1, 16'h4000); chk("rst_mid", 4'd0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            cyc(0, 1, 16'($urandom));
        end

        for (int i = 0; i < 65536; i++) begin
            cyc(0, 1, 16'(i));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
